// File: rtl/tytra_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tytra_stream_pkg
// Description : Shared constants and helpers for packed multi-lane streams.
// Revision    : 1.0 - initial release
// ============================================================================
package tytra_stream_pkg;

    localparam int STREAMW_DEFAULT = 34;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Low bit index of a lane inside a packed NCH*width vector
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/coriolis_stream_join_balance_if.sv
`default_nettype none
// ============================================================================
// Module      : coriolis_stream_join_balance_if
// Description : Multi-channel valid/ready input streams plus joined output.
// Revision    : 1.0 - initial release
// ============================================================================
interface coriolis_stream_join_balance_if #(
    parameter int NCH     = 2,
    parameter int STREAMW = tytra_stream_pkg::STREAMW_DEFAULT
);
    logic [NCH-1:0]         ivalid_s;
    logic [NCH-1:0]         iready_s;
    logic [NCH*STREAMW-1:0] in_s;
    logic                   ovalid;
    logic                   oready;
    logic [NCH*STREAMW-1:0] out_s;

    modport master (
        output ivalid_s, in_s, oready,
        input  iready_s, ovalid, out_s
    );

    modport slave (
        input  ivalid_s, in_s, oready,
        output iready_s, ovalid, out_s
    );
endinterface
`default_nettype wire

// File: rtl/tytra_fwft_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tytra_fwft_fifo
// Description : First-word-fall-through circular buffer with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module tytra_fwft_fifo
    import tytra_stream_pkg::*;
#(
    parameter  int STREAMW = STREAMW_DEFAULT,
    parameter  int DEPTH   = 16,
    localparam int AW      = clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               push,
    input  wire logic               pop,
    input  wire logic [STREAMW-1:0] din,
    output logic      [STREAMW-1:0] dout,
    output logic      [CW-1:0]      count,
    output logic                    full,
    output logic                    empty
);
    logic [STREAMW-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               w_wr;
    logic               w_rd;

    // Guard locally so a misbehaving caller cannot corrupt the count
    assign w_wr = push & ~full;
    assign w_rd = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/coriolis_stream_join_balance.sv
`default_nettype none
// ============================================================================
// Module      : coriolis_stream_join_balance
// Description : Joins NCH elastic-buffered streams into one concatenated word.
// Revision    : 1.0 - initial release
// ============================================================================
module coriolis_stream_join_balance
    import tytra_stream_pkg::*;
#(
    parameter int STREAMW = STREAMW_DEFAULT,
    parameter int NCH     = 2,
    parameter int DEPTH   = 16,
    parameter int CNTW    = clog2(DEPTH) + 1
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    coriolis_stream_join_balance_if.slave bus,
    output logic      [NCH*CNTW-1:0]   lvl_s,
    output logic                       skew_err
);
    logic [NCH-1:0]  w_full;
    logic [NCH-1:0]  w_empty;
    logic [NCH-1:0]  w_push;
    logic [CNTW-1:0] w_count [NCH];
    logic            w_pop;
    logic            r_skew_err;

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_lane
            // Ready comes only from registered occupancy; no path from oready
            assign bus.iready_s[c] = ~rst & ~w_full[c];
            assign w_push[c]       = bus.ivalid_s[c] & bus.iready_s[c];

            tytra_fwft_fifo #(
                .STREAMW (STREAMW),
                .DEPTH   (DEPTH)
            ) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (w_push[c]),
                .pop   (w_pop),
                .din   (bus.in_s[lane_lo(c, STREAMW) +: STREAMW]),
                .dout  (bus.out_s[lane_lo(c, STREAMW) +: STREAMW]),
                .count (w_count[c]),
                .full  (w_full[c]),
                .empty (w_empty[c])
            );

            assign lvl_s[c*CNTW +: CNTW] = w_count[c];
        end
    endgenerate

    assign bus.ovalid = ~|w_empty;
    assign w_pop      = bus.ovalid & bus.oready;

    // A full lane alongside an empty lane means DEPTH cannot absorb the skew
    always_ff @(posedge clk) begin
        if (rst) begin
            r_skew_err <= 1'b0;
        end else if (|w_full && |w_empty) begin
            r_skew_err <= 1'b1;
        end
    end

    assign skew_err = r_skew_err;

endmodule
`default_nettype wire
